// File: rtl/barret_pkg.sv
// rtl/barret_pkg.sv - width and constant helpers for the Barrett reducer
package barret_pkg;

  function automatic int clog2(input longint v);
    int     r;
    longint t;
    r = 0;
    t = v - 1;
    while (t > 0) begin
      r++;
      t = t >> 1;
    end
    return r;
  endfunction

  // floor(2^k / q); k can reach 32, so the shift is done in 64 bits
  function automatic longint barret_mu(input longint q, input int k);
    return (longint'(1) << k) / q;
  endfunction

  function automatic int barret_qw(input int q);
    return clog2(longint'(q));
  endfunction

  function automatic int barret_k(input int qw);
    return 2 * qw;
  endfunction

endpackage

// File: rtl/barret_corr.sv
// rtl/barret_corr.sv - two-step conditional subtract, maps r0 in [0, 3Q) to [0, Q)
module barret_corr
  import barret_pkg::*;
#(
  parameter int Q  = 1481,
  parameter int QW = 11
) (
  input  logic [QW+1:0] r0,
  output logic [QW-1:0] r
);

  localparam logic [QW+1:0] QV = (QW+2)'(Q);

  logic [QW+1:0] r1;
  logic [QW+1:0] r2;
  logic          unused_hi;

  always_comb begin
    r1 = r0;
    r2 = r0;
    if (r0 >= QV) r1 = r0 - QV;
    r2 = r1;
    if (r1 >= QV) r2 = r1 - QV;
  end

  assign r         = r2[QW-1:0];
  assign unused_hi = ^r2[QW+1:QW];

endmodule

// File: rtl/barret_reduce_pipe.sv
// rtl/barret_reduce_pipe.sv - 3-stage pipelined Barrett reducer, dout_r = din_a mod Q
module barret_reduce_pipe
  import barret_pkg::*;
#(
  parameter int     Q     = 1481,
  parameter int     QW    = barret_qw(Q),
  parameter int     DW    = 2 * QW - 1,
  parameter int     K     = barret_k(QW),
  parameter longint MU    = barret_mu(longint'(Q), K),
  parameter int     TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    din_a,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QW-1:0]    dout_r,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = DW + K;
  localparam int SW = DW + 2;
  localparam int RW = QW + 2;

  if ((Q % 2) == 0 || DW > 2 * QW) begin : g_bad_param
    $error("barret_reduce_pipe: Q must be odd and DW <= 2*QW");
  end

  logic             adv;
  logic             ready_en;
  logic             accept;
  logic             v1;
  logic             v2;
  logic [DW-1:0]    x1;
  logic [PW-1:0]    p1;
  logic [TAG_W-1:0] t1;
  logic [RW-1:0]    r0_q;
  logic [TAG_W-1:0] t2;
  logic [PW-1:0]    p_next;
  logic [DW-1:0]    qh;
  logic [SW-1:0]    r0_full;
  logic [QW-1:0]    r2;
  logic             unused_bits;

  // ready_en keeps the input closed until the first edge after reset release
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && ready_en;
  assign accept   = in_valid && in_ready;

  assign p_next  = PW'(din_a) * PW'(MU);
  assign qh      = p1[PW-1:K];
  // true value lies in [0, 3Q), so the low RW bits of the wrapped difference are exact
  assign r0_full = SW'(x1) - SW'(qh) * SW'(Q);

  assign unused_bits = ^{p1[K-1:0], r0_full[SW-1:RW]};

  barret_corr #(
    .Q  (Q),
    .QW (QW)
  ) u_corr (
    .r0 (r0_q),
    .r  (r2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en  <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      x1        <= '0;
      p1        <= '0;
      t1        <= '0;
      r0_q      <= '0;
      t2        <= '0;
      dout_r    <= '0;
      out_tag   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (adv) begin
        v1        <= accept;
        v2        <= v1;
        out_valid <= v2;
        if (accept) begin
          x1 <= din_a;
          p1 <= p_next;
          t1 <= in_tag;
        end
        if (v1) begin
          r0_q <= r0_full[RW-1:0];
          t2   <= t1;
        end
        if (v2) begin
          dout_r  <= r2;
          out_tag <= t2;
        end
      end
    end
  end

endmodule

// File: tb/tb_barret_reduce_pipe.sv
// tb/tb_barret_reduce_pipe.sv - scoreboard bench for barret_reduce_pipe (Q=1481 and Q=3329)
module tb_barret_reduce_pipe;

  localparam int Q1  = 1481;
  localparam int QW1 = 11;
  localparam int DW1 = 21;
  localparam int Q2  = 3329;
  localparam int QW2 = 12;
  localparam int DW2 = 23;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [DW1-1:0] din_a = '0;
  logic [7:0]     in_tag = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [QW1-1:0] dout_r;
  logic [7:0]     out_tag;

  logic           in_valid2 = 1'b1;
  logic           in_ready2;
  logic [DW2-1:0] din2 = '0;
  logic [7:0]     tag2 = '0;
  logic           out_valid2;
  logic           out_ready2 = 1'b1;
  logic [QW2-1:0] dout2;
  logic [7:0]     out_tag2;

  barret_reduce_pipe #(.Q(Q1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .din_a(din_a),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .dout_r(dout_r),
    .out_tag(out_tag)
  );

  barret_reduce_pipe #(.Q(Q2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .din_a(din2),
    .in_tag(tag2), .out_valid(out_valid2), .out_ready(out_ready2), .dout_r(dout2),
    .out_tag(out_tag2)
  );

  int checks = 0;
  int errors = 0;
  int exp_r[$];
  int exp_t[$];
  int q2r[$];
  int q2t[$];
  int n2 = 0;
  bit rand_ready = 1'b0;
  bit prev_stall = 1'b0;
  int prev_r = 0;
  int prev_t = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard for the Q=1481 instance: push on accept, pop on retire
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_r.push_back(int'(din_a) % Q1);
        exp_t.push_back(int'(in_tag));
      end
      if (out_valid && out_ready) begin
        if (exp_r.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          chk("dout_r", dout_r, exp_r.pop_front());
          chk("out_tag", out_tag, exp_t.pop_front());
        end
      end
      if (prev_stall && out_valid) begin
        chk("stall_hold_r", dout_r, prev_r);
        chk("stall_hold_tag", out_tag, prev_t);
      end
      if (out_valid && !out_ready) chk("in_ready_during_stall", in_ready, 0);
      prev_stall = out_valid && !out_ready;
      prev_r     = int'(dout_r);
      prev_t     = int'(out_tag);
    end
  end

  // Q=3329 instance runs a free random stream for the whole simulation
  always begin
    @(posedge clk);
    #1;
    din2       = DW2'($urandom_range(0, (1 << DW2) - 1));
    tag2       = tag2 + 8'd1;
    out_ready2 = ($urandom_range(0, 3) != 0);
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid2 && in_ready2) begin
        q2r.push_back(int'(din2) % Q2);
        q2t.push_back(int'(tag2));
      end
      if (out_valid2 && out_ready2) begin
        if (q2r.size() == 0) chk("dut2_unexpected_beat", 1, 0);
        else begin
          chk("dut2_dout_r", dout2, q2r.pop_front());
          chk("dut2_out_tag", out_tag2, q2t.pop_front());
          n2++;
        end
      end
    end
  end

  task automatic send(input int x, input int tg);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    din_a = DW1'(x);
    in_tag = 8'(tg);
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send_lat(input int x, input int tg);
    int lat;
    send(x, tg);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_r.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", exp_r.size(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dout_r", dout_r, 0);
    chk("rst_out_tag", out_tag, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_release", in_ready, 1);

    // sweep of the residue range, first beat timed
    send_lat(0, 0);
    for (int x = 1; x < Q1; x++) send(x, x & 255);
    drain();

    // boundaries around multiples of Q and the top of the operand range
    send(1481, 1);
    send(2962, 2);
    send(2963, 3);
    send(2097151, 4);
    send(1480, 5);
    send(2097150, 6);
    drain();

    // stall of 5 clocks in the middle of a 10-beat stream
    fork
      begin
        for (int i = 0; i < 10; i++) send(5000 + i * 777, 100 + i);
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // random traffic with gaps on both sides
    rand_ready = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        send(int'($urandom_range(0, (1 << DW1) - 1)), i & 255);
      end
    end
    in_valid = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    drain();

    // reset with three operands in flight
    send(100, 10);
    send(200, 11);
    send(300, 12);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_dout_r", dout_r, 0);
    chk("midrst_out_tag", out_tag, 0);
    exp_r.delete();
    exp_t.delete();
    q2r.delete();
    q2t.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_no_partial", out_valid, 0);
    send_lat(1500, 77);
    chk("post_rst_result", dout_r, 19);
    drain();

    chk("dut2_beats_seen", (n2 > 1000) ? 1 : 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
